// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd input/weight schedulers.
package wino_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREPARE = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } sched_state_t;

  localparam int ID_W_DEF  = 4;
  localparam int BLK_DIM_W = 8;

  // The data controller fetches two blocks per request, so the area must be even and non-trivial.
  function automatic logic geom_ok(input logic [BLK_DIM_W-1:0] w, input logic [BLK_DIM_W-1:0] h);
    logic [15:0] area;
    area = 16'(w) * 16'(h);
    return (area >= 16'd2) && !area[0];
  endfunction

endpackage

// File: rtl/wino_input_scheduler_if.sv
// Scheduler <-> Winograd input data controller link: ID/prepare/geometry out, completion/valid back.
interface wino_input_scheduler_if #(
  parameter int ID_W = wino_pkg::ID_W_DEF
) ();
  import wino_pkg::*;

  logic [ID_W-1:0]      input_id_o;
  logic                 input_prepare_o;
  logic [BLK_DIM_W-1:0] block_width_o;
  logic [BLK_DIM_W-1:0] block_height_o;
  logic                 size_type_o;
  logic                 loop_finished_i;
  logic                 data_valid_i;

  modport master (
    output input_id_o, input_prepare_o, block_width_o, block_height_o, size_type_o,
    input  loop_finished_i, data_valid_i
  );

  modport slave (
    input  input_id_o, input_prepare_o, block_width_o, block_height_o, size_type_o,
    output loop_finished_i, data_valid_i
  );
endinterface

// File: rtl/wino_drain_timer.sv
// Counts consecutive cycles without data_valid_i while enabled; any valid restarts the count.
// expired_o is combinational and fires in the cycle the count reaches DRAIN_CYCLES.
module wino_drain_timer #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic data_valid_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int            CW   = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (data_valid_i)       cnt_d = '0;
      else if (cnt_q <= LAST) cnt_d = cnt_q + CW'(1);
    end
  end

  assign expired_o = en_i && !data_valid_i && (cnt_q >= LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wino_input_scheduler.sv
// Walks input IDs 0..last_id through the Winograd input data controller: prepare, stream, drain, advance.
// Optional WINO_SCHED_PERF_EN adds a run_cycles_o busy-cycle counter.
module wino_input_scheduler
  import wino_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int ID_W         = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ID_W-1:0]      last_id_i,
  input  logic [BLK_DIM_W-1:0] block_width_i,
  input  logic [BLK_DIM_W-1:0] block_height_i,
  input  logic                 size_type_i,
  wino_input_scheduler_if.master dc,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_err_o,
  output logic [15:0]          tile_pairs_o
`ifdef WINO_SCHED_PERF_EN
  ,
  output logic [31:0]          run_cycles_o
`endif
);
  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_PREPARE = PREPARE;
  localparam logic [2:0] ST_STREAM  = STREAM;
  localparam logic [2:0] ST_DRAIN   = DRAIN;
  localparam logic [2:0] ST_NEXT    = NEXT;
  localparam logic [2:0] ST_DONE    = DONE;

  logic [2:0]           state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d, last_q, last_d;
  logic [BLK_DIM_W-1:0] bw_q, bw_d, bh_q, bh_d;
  logic                 st_q, st_d;
  logic [15:0]          tp_q, tp_d;
  logic                 prep_q, busy_q, done_q, cfg_err_q, cfg_err_d;
  logic                 start_ok, drain_clr, drain_exp;

  assign start_ok = (state_q == ST_IDLE) && start_i && geom_ok(block_width_i, block_height_i);

  wino_drain_timer #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_drain (
    .clk          (clk),
    .reset        (reset),
    .en_i         (state_q == ST_DRAIN),
    .data_valid_i (dc.data_valid_i),
    .clr_i        (drain_clr),
    .expired_o    (drain_exp)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    bw_d      = bw_q;
    bh_d      = bh_q;
    st_d      = st_q;
    tp_d      = tp_q;
    cfg_err_d = 1'b0;
    drain_clr = 1'b0;
    if (busy_q && dc.data_valid_i && (tp_q != 16'hFFFF)) tp_d = tp_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          last_d  = last_id_i;
          bw_d    = block_width_i;
          bh_d    = block_height_i;
          st_d    = size_type_i;
          id_d    = '0;
          tp_d    = '0;
          state_d = ST_PREPARE;
        end else if (start_i) begin
          cfg_err_d = 1'b1;
        end
      end
      ST_PREPARE: state_d = ST_STREAM;
      ST_STREAM: begin
        if (dc.loop_finished_i) begin
          state_d   = ST_DRAIN;
          drain_clr = 1'b1;
        end
      end
      ST_DRAIN: if (drain_exp) state_d = ST_NEXT;
      ST_NEXT: begin
        if (id_q == last_q) begin
          state_d = ST_DONE;
        end else begin
          id_d    = id_q + ID_W'(1);
          state_d = ST_PREPARE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides every other transition; registered outputs follow state_d, so no prepare/done.
    if (abort_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      last_q    <= '0;
      bw_q      <= '0;
      bh_q      <= '0;
      st_q      <= 1'b0;
      tp_q      <= '0;
      prep_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      bw_q      <= bw_d;
      bh_q      <= bh_d;
      st_q      <= st_d;
      tp_q      <= tp_d;
      prep_q    <= (state_d == ST_PREPARE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      cfg_err_q <= cfg_err_d;
    end
  end

  assign dc.input_id_o      = id_q;
  assign dc.input_prepare_o = prep_q;
  assign dc.block_width_o   = bw_q;
  assign dc.block_height_o  = bh_q;
  assign dc.size_type_o     = st_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign cfg_err_o          = cfg_err_q;
  assign tile_pairs_o       = tp_q;

`ifdef WINO_SCHED_PERF_EN
  logic [31:0] run_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         run_q <= '0;
    else if (start_ok) run_q <= '0;
    else if (busy_q)   run_q <= run_q + 32'd1;
  end

  assign run_cycles_o = run_q;
`endif
endmodule
